// File: rtl/sha256_block_sequencer.sv
// Feeds pre-padded 512-bit blocks through an iterative sha256_transform, owns the
// chaining value across the blocks of a message and hands out the final digest.
module sha256_block_sequencer #(
    parameter int           LOOP = 4,
    parameter logic [255:0] IV   = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_last,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         busy,
    output logic         xf_feedback,
    output logic [5:0]   xf_cnt,
    output logic [255:0] xf_rx_state,
    output logic [511:0] xf_rx_input,
    input  logic [255:0] xf_tx_hash
);

    // Both ports: a transfer happens on a rising clk edge where valid and ready are
    // both high; the source holds valid and data stable until that edge.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ROUND   = 3'd1,
        CAPTURE = 3'd2,
        UPDATE  = 3'd3,
        OUT     = 3'd4
    } state_t;

    localparam logic [5:0] CNT_MASK = 6'(LOOP - 1);

    state_t        state;
    state_t        state_nx;
    logic [5:0]    round;
    logic          last_q;
    logic [255:0]  chain;
    logic [511:0]  blk_q;

    assign xf_rx_state = chain;
    assign xf_rx_input = blk_q;

    always_comb begin
        state_nx    = state;
        blk_ready   = 1'b0;
        xf_feedback = 1'b0;
        xf_cnt      = 6'd0;
        case (state)
            IDLE: begin
                // Held low while rst_n is asserted so nothing is offered during reset.
                blk_ready = rst_n;
                if (blk_valid) begin
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                xf_cnt      = round & CNT_MASK;
                xf_feedback = |(round & CNT_MASK);
                if (round == 6'd63) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: state_nx = UPDATE;
            UPDATE:  state_nx = last_q ? OUT : IDLE;
            OUT: begin
                if (dig_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            chain     <= IV;
            blk_q     <= '0;
            round     <= 6'd0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            dig_valid <= 1'b0;
            dig_data  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        blk_q  <= blk_data;
                        last_q <= blk_last;
                        round  <= 6'd0;
                        busy   <= 1'b1;
                    end
                end
                ROUND: round <= round + 6'd1;
                UPDATE: begin
                    // The transform already added the old chain; just take its result.
                    chain <= xf_tx_hash;
                    if (last_q) begin
                        dig_data  <= xf_tx_hash;
                        dig_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        chain     <= IV;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
- Sequencer that drives one iterative sha256_transform instance (same LOOP) to hash multi-block messages.
- Accepts pre-padded 512-bit blocks over valid/ready with a last flag.
- Owns the chaining value, generates the feedback/cnt round schedule, and returns the 256-bit digest over valid/ready.
- Sits between the signature datapath's message buffer and the transform.

Parameters:
- LOOP, 4, rounds per transform stage; must match the attached transform; legal values 1,2,4,8,16,32,64.
- IV, 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667, initial chaining value; word a is in [31:0], word h is in [255:224].

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- blk_valid  in  1  block offered
- blk_ready  out  1  block accepted when valid&ready
- blk_data  in  512  message block, word W0 in [31:0]
- blk_last  in  1  final block of message
- dig_valid  out  1  digest available
- dig_ready  in  1  digest consumed when valid&ready
- dig_data  out  256  final digest, same word order as IV
- busy  out  1  high from block accept until digest handshake
- xf_feedback  out  1  to transform feedback
- xf_cnt  out  6  to transform cnt
- xf_rx_state  out  256  to transform rx_state (chaining register)
- xf_rx_input  out  512  to transform rx_input (block register)
- xf_tx_hash  in  256  from transform tx_hash

Behaviour:
- Reset (sync, rst_n=0 at posedge) values:
  - state IDLE, chain=IV, blk_ready=0, dig_valid=0, dig_data=0, busy=0.
  - xf_feedback=0, xf_cnt=0, round=0, last_q=0.
  - A reset mid-block or mid-output drops all work with no output.
- Transform reset: the transform shares rst_n, so the sequencer and transform reset together.
- States: IDLE, ROUND, CAPTURE, UPDATE, OUT.
- IDLE:
  - blk_ready=1.
  - On handshake: latch blk_data into the block register, latch blk_last into last_q, set round=0, go to ROUND.
  - Present xf_feedback=0 and xf_cnt=0 in the cycle the data is latched, so the transform stage 0 loads at the next edge.
- ROUND, 64 cycles with r=0..63:
  - xf_cnt = r mod LOOP; xf_feedback = (r mod LOOP != 0).
  - round increments by 1 each cycle.
  - After r=63, go to CAPTURE.
- CAPTURE, 1 cycle:
  - xf_feedback=0, xf_cnt=0, so the transform registers xf_tx_hash = chain + final state.
  - Go to UPDATE.
- UPDATE, 1 cycle:
  - chain <= xf_tx_hash.
  - If last_q, go to OUT with dig_data <= xf_tx_hash and dig_valid <= 1.
  - Otherwise go to IDLE; the chain carries to the next block.
- OUT:
  - Hold dig_valid and dig_data stable until dig_ready.
  - On handshake: dig_valid=0, chain=IV, go to IDLE.
- Stability rules:
  - xf_rx_state and xf_rx_input must stay constant from accept through CAPTURE.
  - blk_ready=0 in every state except IDLE.
- Latency:
  - Accept edge to UPDATE edge is 66 cycles.
  - Single-block digest: dig_valid rises 66 cycles after the accept edge.
  - Non-last block: blk_ready returns 66 cycles after the accept edge.
- busy:
  - Set on accept; cleared on the digest handshake.
  - Stays high between blocks of one message while in IDLE awaiting the next block.
- A dig_ready asserted without dig_valid is ignored.
- A blk_valid asserted while not ready is not consumed, and the data may change freely.
- Width: all chain arithmetic is done in the transform (mod 2^32 per word); the sequencer performs no addition.

Test Plan:
- Block-level directed scenarios:
  - Single block "abc" (61626380 then zeros, length word 0x18), blk_last=1 -> dig_data words a..h = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, dig_valid exactly 66 cycles after the accept edge.
  - Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmmnopnopq" (448-bit message), second block blk_last=1 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; blk_ready low for 66 cycles between the blocks.
  - Hold dig_ready=0 for 20 cycles after dig_valid -> dig_data stable and blk_ready=0 throughout; after the handshake a second "abc" message yields the same digest (chain restored to IV).
- Timing and reset checks:
  - Sweep LOOP=1,2,4,8 -> the "abc" digest is identical; xf_cnt traces 0..LOOP-1 repeating; xf_feedback=0 only at r multiple of LOOP and in CAPTURE.
  - rst_n=0 for 1 cycle at round 30 of the first block of a two-block message -> no dig_valid, busy=0, blk_ready=1 next cycle; a subsequent "abc" produces the correct digest.
  - Toggle blk_valid with changing data while busy -> no extra accepts; the digest is unaffected.
